// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shared state and direction encodings for the shift arbiter
package shift_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COOLDOWN} state_e;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;
endpackage

// File: rtl/shift_arbiter_edge_pend.sv
// shift_arbiter_edge_pend: per-requester press detection and single pending move slot
module shift_arbiter_edge_pend
  import shift_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic left_i,
  input  logic right_i,
  input  logic clr_i,
  output logic pend_o,
  output dir_e dir_o
);
  logic left_q, right_q, pend_q, pend_d, le, re;
  dir_e dir_q, dir_d;
  // Simultaneous left+right presses cancel, mirroring the shifter's both-pressed rule.
  always_comb begin
    le = left_i & ~left_q;
    re = right_i & ~right_q;
    pend_d = pend_q ? ~clr_i : le ^ re;
    dir_d = (!pend_q && (le ^ re)) ? (re ? DIR_RIGHT : DIR_LEFT) : dir_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      left_q <= 1'b0;
      right_q <= 1'b0;
      pend_q <= 1'b0;
      dir_q <= DIR_LEFT;
    end else begin
      left_q <= left_i;
      right_q <= right_i;
      pend_q <= pend_d;
      dir_q <= dir_d;
    end
  end
  assign pend_o = pend_q;
  assign dir_o = dir_q;
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin, rate-limited, boundary-checked sharing of a one-hot shifter
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int COOLDOWN = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_left,
  input  logic [1:0]       req_right,
  output logic             shift_left,
  output logic             shift_right,
  output logic [1:0]       grant,
  output logic [1:0]       reject,
  output logic [WIDTH-1:0] pos,
  output logic             busy
);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [WIDTH-1:0] PMIN = WIDTH'(1);
  localparam logic [WIDTH-1:0] PMAX = PMIN << (WIDTH - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic sl_q, sl_d, sr_q, sr_d, last_q, last_d, win, legal;
  logic [1:0] grant_q, grant_d, reject_q, reject_d, pend, clr;
  dir_e dir [2];
  dir_e wdir;
  for (genvar i = 0; i < 2; i++) begin : g_ep
    shift_arbiter_edge_pend u_ep (
      .clk     (clk),
      .rst     (rst),
      .left_i  (req_left[i]),
      .right_i (req_right[i]),
      .clr_i   (clr[i]),
      .pend_o  (pend[i]),
      .dir_o   (dir[i])
    );
  end
  always_comb begin
    win = (pend == 2'b11) ? ~last_q : pend[1];
    wdir = dir[win];
    legal = (wdir == DIR_LEFT) ? (pos_q != PMAX) : (pos_q != PMIN);
    state_d = state_q;
    cnt_d = cnt_q;
    pos_d = pos_q;
    last_d = last_q;
    sl_d = 1'b0;
    sr_d = 1'b0;
    grant_d = 2'b00;
    reject_d = 2'b00;
    clr = 2'b00;
    case (state_q)
      S_IDLE: if (|pend) begin
        clr = 2'b01 << win;
        if (legal) begin
          state_d = S_ISSUE;
          last_d = win;
          sl_d = (wdir == DIR_LEFT);
          sr_d = (wdir == DIR_RIGHT);
          grant_d = 2'b01 << win;
        end else begin
          reject_d = 2'b01 << win;
        end
      end
      S_ISSUE: begin
        pos_d = sl_q ? pos_q << 1 : pos_q >> 1;
        state_d = (COOLDOWN > 0) ? S_COOLDOWN : S_IDLE;
        cnt_d = CD_LOAD;
      end
      S_COOLDOWN: begin
        state_d = (cnt_q == '0) ? S_IDLE : S_COOLDOWN;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      pos_q <= PMIN;
      last_q <= 1'b1;
      sl_q <= 1'b0;
      sr_q <= 1'b0;
      grant_q <= 2'b00;
      reject_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      last_q <= last_d;
      sl_q <= sl_d;
      sr_q <= sr_d;
      grant_q <= grant_d;
      reject_q <= reject_d;
    end
  end
  assign shift_left = sl_q;
  assign shift_right = sr_q;
  assign grant = grant_q;
  assign reject = reject_q;
  assign pos = pos_q;
  assign busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed scoreboard bench for shift_arbiter against a one-hot shifter model
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_left = 2'b00, req_right = 2'b00;
  logic shift_left, shift_right, busy;
  logic [1:0] grant, reject;
  logic [3:0] pos, sh_out;
  typedef struct packed {logic sl; logic sr; logic [1:0] gnt; logic [1:0] rej; logic [3:0] pos;} ev_t;
  ev_t exp_q[$];
  ev_t e;
  int checks = 0, failures = 0, nb;
  always #5 clk = ~clk;
  shift_arbiter #(.COOLDOWN(4), .WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_left    (req_left),
    .req_right   (req_right),
    .shift_left  (shift_left),
    .shift_right (shift_right),
    .grant       (grant),
    .reject      (reject),
    .pos         (pos),
    .busy        (busy)
  );
  // Shifter being driven: shift_left moves the hot bit up, shift_right down.
  always @(posedge clk)
    sh_out <= rst ? 4'b0001 : (shift_left && !shift_right) ? sh_out << 1 : (shift_right && !shift_left) ? sh_out >> 1 : sh_out;
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic ev_t ev(logic sl, logic sr, logic [1:0] g, logic [1:0] r, logic [3:0] p);
    return {sl, sr, g, r, p};
  endfunction
  always @(negedge clk) begin
    chk("pos_vs_shifter", 8'(pos), 8'(sh_out));
    chk("no_both_pulses", 8'(shift_left & shift_right), 8'd0);
    if (!(shift_left || shift_right)) chk("grant_without_pulse", 8'(grant), 8'd0);
    if (shift_left || shift_right || reject != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 8'({shift_left, shift_right, grant, reject}), 8'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_dir", 8'({shift_left, shift_right}), 8'({e.sl, e.sr}));
        chk("ev_grant", 8'(grant), 8'(e.gnt));
        chk("ev_reject", 8'(reject), 8'(e.rej));
        chk("ev_pos", 8'(pos), 8'(e.pos));
      end
    end
  end
  initial begin
    tick(2);
    chk("rst_pos", 8'(pos), 8'h01);
    chk("rst_shift", 8'({shift_left, shift_right}), 8'd0);
    chk("rst_grant", 8'(grant), 8'd0);
    chk("rst_reject", 8'(reject), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    rst = 1'b0;
    tick(1);
    exp_q.push_back(ev(1'b1, 1'b0, 2'b01, 2'b00, 4'b0001));
    req_left[0] = 1'b1;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (i == 0) chk("lat_not_early", 8'(shift_left), 8'd0);
      if (i == 1) begin
        chk("lat_shift_left", 8'(shift_left), 8'd1);
        chk("lat_grant", 8'(grant), 8'h01);
      end
      if (i == 9) req_left[0] = 1'b0;
      nb += int'(busy);
    end
    chk("busy_cycles", 8'(nb), 8'd5);
    chk("held_pos", 8'(pos), 8'h02);
    // last grant is now requester 0, so requester 1 wins the tie
    exp_q.push_back(ev(1'b0, 1'b1, 2'b10, 2'b00, 4'b0010));
    exp_q.push_back(ev(1'b1, 1'b0, 2'b01, 2'b00, 4'b0001));
    req_left[0] = 1'b1;
    req_right[1] = 1'b1;
    tick(2);
    req_left = 2'b00;
    req_right = 2'b00;
    tick(16);
    chk("tie1_drained", 8'(exp_q.size()), 8'd0);
    chk("tie1_pos", 8'(pos), 8'h02);
    exp_q.push_back(ev(1'b1, 1'b0, 2'b10, 2'b00, 4'b0010));
    exp_q.push_back(ev(1'b0, 1'b1, 2'b01, 2'b00, 4'b0100));
    req_left[1] = 1'b1;
    req_right[0] = 1'b1;
    tick(2);
    req_left = 2'b00;
    req_right = 2'b00;
    tick(16);
    chk("tie2_drained", 8'(exp_q.size()), 8'd0);
    chk("tie2_pos", 8'(pos), 8'h02);
    exp_q.push_back(ev(1'b0, 1'b1, 2'b01, 2'b00, 4'b0010));
    req_right[0] = 1'b1;
    tick(2);
    req_right[0] = 1'b0;
    tick(6);
    chk("to_min_pos", 8'(pos), 8'h01);
    exp_q.push_back(ev(1'b0, 1'b0, 2'b00, 2'b10, 4'b0001));
    req_right[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i == 1) req_right[1] = 1'b0;
      chk("rej_min_busy", 8'(busy), 8'd0);
    end
    chk("rej_min_drained", 8'(exp_q.size()), 8'd0);
    chk("rej_min_pos", 8'(pos), 8'h01);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev(1'b1, 1'b0, 2'b01, 2'b00, 4'b0001 << i));
      req_left[0] = 1'b1;
      tick(2);
      req_left[0] = 1'b0;
      tick(6);
    end
    chk("to_max_pos", 8'(pos), 8'h08);
    exp_q.push_back(ev(1'b0, 1'b0, 2'b00, 2'b01, 4'b1000));
    req_left[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i == 1) req_left[0] = 1'b0;
      chk("rej_max_busy", 8'(busy), 8'd0);
    end
    chk("rej_max_drained", 8'(exp_q.size()), 8'd0);
    chk("rej_max_pos", 8'(pos), 8'h08);
    req_left[0] = 1'b1;
    req_right[0] = 1'b1;
    tick(2);
    req_left = 2'b00;
    req_right = 2'b00;
    tick(8);
    chk("both_dirs_busy", 8'(busy), 8'd0);
    chk("both_dirs_pos", 8'(pos), 8'h08);
    exp_q.push_back(ev(1'b0, 1'b1, 2'b01, 2'b00, 4'b1000));
    req_right[0] = 1'b1;
    tick(2);
    req_right[0] = 1'b0;
    req_right[1] = 1'b1;
    tick(2);
    chk("rst_mid_cooldown_busy", 8'(busy), 8'd1);
    rst = 1'b1;
    req_right = 2'b00;
    tick(1);
    chk("rst_mid_busy", 8'(busy), 8'd0);
    chk("rst_mid_pos", 8'(pos), 8'h01);
    chk("rst_mid_shifter", 8'(sh_out), 8'h01);
    rst = 1'b0;
    tick(15);
    chk("rst_mid_drained", 8'(exp_q.size()), 8'd0);
    chk("rst_mid_pos_after", 8'(pos), 8'h01);
    chk("rst_mid_busy_after", 8'(busy), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
